// File: rtl/qam_burst_framer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : qam_frame_pkg
//  Brief    : Shared types and symbol constants for the 16-QAM burst framer.
//  Revision : 1.0  initial release
// ============================================================================
package qam_frame_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CARRIER  = 3'd1,
        PREAMBLE = 3'd2,
        SFD      = 3'd3,
        PAYLOAD  = 3'd4,
        GUARD    = 3'd5
    } frame_state_e;

    localparam logic [1:0] c_carrier_i = 2'd3;
    localparam logic [1:0] c_carrier_q = 2'd0;
    localparam logic [1:0] c_pre_hi    = 2'd3;
    localparam logic [1:0] c_pre_lo    = 2'd0;
    localparam logic [3:0] c_filler    = 4'b0110;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qam_burst_framer_if.sv
`default_nettype none
// ============================================================================
//  Module   : qam_burst_framer_if
//  Brief    : Payload stream (valid/ready) and modulator symbol bus.
//  Revision : 1.0  initial release
// ============================================================================
interface qam_burst_framer_if;
    logic [3:0] in_sym;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] i;
    logic [1:0] q;
    logic       mod_en;

    modport master (output in_sym, output in_valid,
                    input  in_ready, input i, input q, input mod_en);
    modport slave  (input  in_sym, input in_valid,
                    output in_ready, output i, output q, output mod_en);
endinterface
`default_nettype wire

// File: rtl/qam_burst_framer.sv
`default_nettype none
// ============================================================================
//  Module   : qam_burst_framer
//  Brief    : Sequences carrier, preamble, SFD, payload and guard symbols.
//  Revision : 1.0  initial release
// ============================================================================
module qam_burst_framer
    import qam_frame_pkg::*;
#(
    parameter int          CW_LEN    = 8,
    parameter int          PRE_LEN   = 16,
    parameter logic [15:0] SFD_WORD  = 16'hE4B1,
    parameter int          GUARD_LEN = 4,
    parameter int          LEN_W     = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             sym_en,
    input  wire logic             start,
    input  wire logic [LEN_W-1:0] len,
    input  wire logic             abort,
    qam_burst_framer_if.slave     bus,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun
);

    localparam int CNT_W = max_int(LEN_W,
                           $clog2(max_int(CW_LEN, max_int(PRE_LEN, GUARD_LEN))));

    frame_state_e     r_state, w_state_nxt, w_follow;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_follow_cnt;
    logic [LEN_W-1:0] r_len, w_len_nxt;
    logic             r_pend, w_pend_nxt;
    logic [1:0]       r_i, r_q, w_i_nxt, w_q_nxt;
    logic             r_mod_en, w_mod_nxt;
    logic             r_done, w_done_nxt;
    logic             r_und, w_und_nxt;
    logic             w_start_ok;

    assign w_start_ok = start && (len != '0);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_len_nxt    = r_len;
        w_pend_nxt   = r_pend;
        w_i_nxt      = r_i;
        w_q_nxt      = r_q;
        w_mod_nxt    = r_mod_en;
        w_done_nxt   = 1'b0;
        w_und_nxt    = 1'b0;
        w_follow     = IDLE;
        w_follow_cnt = '0;

        // Requests are latched between strobes so a short start pulse is not lost.
        if (r_state == IDLE && w_start_ok) begin
            w_pend_nxt = 1'b1;
            w_len_nxt  = len;
        end

        if (sym_en) begin
            case (r_state)
                CARRIER: begin
                    w_i_nxt      = c_carrier_i;
                    w_q_nxt      = c_carrier_q;
                    w_mod_nxt    = 1'b0;
                    w_follow     = PREAMBLE;
                    w_follow_cnt = CNT_W'(PRE_LEN - 1);
                end
                PREAMBLE: begin
                    w_i_nxt      = r_cnt[0] ? c_pre_hi : c_pre_lo;
                    w_q_nxt      = r_cnt[0] ? c_pre_hi : c_pre_lo;
                    w_mod_nxt    = 1'b1;
                    w_follow     = SFD;
                    w_follow_cnt = CNT_W'(3);
                end
                SFD: begin
                    {w_i_nxt, w_q_nxt} = SFD_WORD[{r_cnt[1:0], 2'b00} +: 4];
                    w_mod_nxt          = 1'b1;
                    w_follow           = PAYLOAD;
                    w_follow_cnt       = CNT_W'(r_len - 1'b1);
                end
                PAYLOAD: begin
                    w_mod_nxt = 1'b1;
                    if (bus.in_valid) begin
                        {w_i_nxt, w_q_nxt} = bus.in_sym;
                    end else begin
                        {w_i_nxt, w_q_nxt} = c_filler;
                        w_und_nxt          = 1'b1;
                    end
                    w_follow     = GUARD;
                    w_follow_cnt = CNT_W'(GUARD_LEN - 1);
                end
                GUARD: begin
                    w_i_nxt   = c_carrier_i;
                    w_q_nxt   = c_carrier_q;
                    w_mod_nxt = 1'b0;
                    w_follow  = IDLE;
                end
                default: begin
                    w_follow = IDLE;
                end
            endcase

            if (r_state == IDLE) begin
                if (w_pend_nxt) begin
                    w_state_nxt = CARRIER;
                    w_cnt_nxt   = CNT_W'(CW_LEN - 1);
                    w_pend_nxt  = 1'b0;
                end
            end else if (abort && r_state != GUARD) begin
                w_state_nxt = GUARD;
                w_cnt_nxt   = CNT_W'(GUARD_LEN - 1);
            end else if (r_cnt == '0) begin
                w_state_nxt = w_follow;
                w_cnt_nxt   = w_follow_cnt;
                w_done_nxt  = (r_state == GUARD);
            end else begin
                w_cnt_nxt = r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_len    <= '0;
            r_pend   <= 1'b0;
            r_i      <= c_carrier_i;
            r_q      <= c_carrier_q;
            r_mod_en <= 1'b0;
            r_done   <= 1'b0;
            r_und    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_len    <= w_len_nxt;
            r_pend   <= w_pend_nxt;
            r_i      <= w_i_nxt;
            r_q      <= w_q_nxt;
            r_mod_en <= w_mod_nxt;
            r_done   <= w_done_nxt;
            r_und    <= w_und_nxt;
        end
    end

    assign bus.in_ready = sym_en && (r_state == PAYLOAD);
    assign bus.i        = r_i;
    assign bus.q        = r_q;
    assign bus.mod_en   = r_mod_en;
    assign busy         = (r_state != IDLE);
    assign done         = r_done;
    assign underrun     = r_und;

endmodule
`default_nettype wire

// File: tb/tb_qam_burst_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qam_burst_framer
//  Brief    : Directed self-checking bench for qam_burst_framer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_qam_burst_framer;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       sym_en = 1'b0;
    logic       start  = 1'b0;
    logic       abort  = 1'b0;
    logic [7:0] len    = 8'd0;
    logic       busy, done, underrun;

    int n_pass   = 0;
    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] exp_q[$];
    logic [3:0] data[$];
    logic [3:0] exp_pay[$];

    qam_burst_framer_if bus();

    qam_burst_framer #(
        .CW_LEN    (8),
        .PRE_LEN   (16),
        .SFD_WORD  (16'hE4B1),
        .GUARD_LEN (4),
        .LEN_W     (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sym_en   (sym_en),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .bus      (bus.slave),
        .busy     (busy),
        .done     (done),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {mod_en,i,q} per strobe: 8 carrier, 16 preamble, SFD E,4,B,1, payload, 4 guard.
    function automatic void build_exp();
        exp_q = {};
        for (int j = 0; j < 8; j++)  exp_q.push_back(5'b0_11_00);
        for (int j = 0; j < 16; j++) exp_q.push_back((j % 2 == 0) ? 5'b1_11_11 : 5'b1_00_00);
        exp_q.push_back(5'b1_1110);
        exp_q.push_back(5'b1_0100);
        exp_q.push_back(5'b1_1011);
        exp_q.push_back(5'b1_0001);
        foreach (exp_pay[j]) exp_q.push_back({1'b1, exp_pay[j]});
        for (int j = 0; j < 4; j++)  exp_q.push_back(5'b0_11_00);
    endfunction

    task automatic strobe(output logic rdy);
        @(negedge clk);
        sym_en = 1'b1;
        #1 rdy = bus.in_ready;
        @(negedge clk);
        sym_en = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] l, input int abort_at, input int under_at,
                             input int busy_start_at, input int exp_rdy, input int exp_und,
                             input string name);
        int   total;
        int   xfer;
        int   pslot;
        int   nrdy;
        int   nund;
        int   ndone;
        logic rdy;
        total = 28 + exp_pay.size() + 4;
        xfer  = 0;
        nrdy  = 0;
        nund  = 0;
        ndone = 0;
        @(negedge clk);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
        len   = 8'd0;
        check({name, "_latched_idle"}, busy, 1'b0);
        strobe(rdy);
        check({name, "_busy_go"}, busy, 1'b1);
        for (int k = 1; k <= total; k++) begin
            pslot = (k >= 29 && k <= 28 + exp_pay.size()) ? k - 28 : 0;
            bus.in_valid = (pslot != 0 && pslot == under_at) ? 1'b0 : 1'b1;
            bus.in_sym   = (xfer < data.size()) ? data[xfer] : 4'h0;
            abort = ((pslot != 0 && pslot == abort_at) || (abort_at != 0 && k == total - 1));
            if (pslot != 0 && pslot == busy_start_at) begin
                start = 1'b1;
                len   = 8'd3;
            end
            strobe(rdy);
            abort = 1'b0;
            start = 1'b0;
            len   = 8'd0;
            if (rdy) begin
                nrdy++;
                if (bus.in_valid) xfer++;
            end
            check($sformatf("%s_sym%0d", name, k), {bus.mod_en, bus.i, bus.q}, exp_q[k-1]);
            if (underrun) nund++;
            if (done) ndone++;
        end
        check({name, "_done_last"}, done, 1'b1);
        check({name, "_done_count"}, ndone, 1);
        check({name, "_busy_end"}, busy, 1'b0);
        check({name, "_ready_count"}, nrdy, exp_rdy);
        check({name, "_underrun_count"}, nund, exp_und);
        @(negedge clk);
        check({name, "_done_pulse_width"}, done, 1'b0);
    endtask

    initial begin
        logic       rdy;
        int         xfer;
        int         nb;
        logic [4:0] s10, s11, s26, s30;

        bus.in_sym   = 4'h0;
        bus.in_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.mod_en, bus.i, bus.q, busy, done, underrun}, 8'b0_11_00_000);
        check("reset_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Nominal len=5 frame, start pulse during payload must be ignored
        data    = '{4'h7, 4'hA, 4'h2, 4'hD, 4'h9};
        exp_pay = '{4'h7, 4'hA, 4'h2, 4'hD, 4'h9};
        build_exp();
        run_frame(8'd5, 0, 0, 2, 5, 0, "norm");
        repeat (3) strobe(rdy);
        check("single_frame_busy", busy, 1'b0);

        // Underrun on payload slot 3
        exp_pay = '{4'h7, 4'hA, 4'h6, 4'h2, 4'hD};
        build_exp();
        run_frame(8'd5, 0, 3, 0, 5, 1, "undr");

        // Abort on payload slot 2 of 10, plus an ignored abort during GUARD
        data    = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
        exp_pay = '{4'h1, 4'h2};
        build_exp();
        run_frame(8'd10, 2, 0, 0, 2, 0, "abrt");

        // start with len=0 is dropped
        @(negedge clk);
        start = 1'b1;
        len   = 8'd0;
        @(negedge clk);
        start = 1'b0;
        strobe(rdy);
        strobe(rdy);
        check("len0_busy", busy, 1'b0);
        check("len0_outputs", {bus.mod_en, bus.i, bus.q}, 5'b0_11_00);

        // Asynchronous reset in the middle of the payload
        data = '{4'h5, 4'h8, 4'h3, 4'h9, 4'h1};
        xfer = 0;
        @(negedge clk);
        start = 1'b1;
        len   = 8'd5;
        @(negedge clk);
        start = 1'b0;
        strobe(rdy);
        for (int k = 1; k <= 30; k++) begin
            bus.in_valid = 1'b1;
            bus.in_sym   = data[xfer];
            strobe(rdy);
            if (rdy) xfer++;
        end
        check("pre_reset_payload", {bus.mod_en, bus.i, bus.q, busy}, 6'b1_1000_1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", {bus.mod_en, bus.i, bus.q, busy}, 6'b0_11_00_0);
        @(negedge clk);
        rst_n = 1'b1;
        data    = '{4'h3, 4'hE};
        exp_pay = '{4'h3, 4'hE};
        build_exp();
        run_frame(8'd2, 0, 0, 0, 2, 0, "rstart");

        // sym_en held high, len=1: one symbol per clock
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sym   = 4'hC;
        start        = 1'b1;
        len          = 8'd1;
        sym_en       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        len   = 8'd0;
        nb    = 0;
        s10   = '0;
        s11   = '0;
        s26   = '0;
        s30   = '0;
        for (int c = 0; c < 100; c++) begin
            if (!busy) break;
            nb++;
            if (nb == 10) s10 = {bus.mod_en, bus.i, bus.q};
            if (nb == 11) s11 = {bus.mod_en, bus.i, bus.q};
            if (nb == 26) s26 = {bus.mod_en, bus.i, bus.q};
            if (nb == 30) s30 = {bus.mod_en, bus.i, bus.q};
            @(negedge clk);
        end
        check("cont_busy_cycles", nb, 33);
        check("cont_done", done, 1'b1);
        check("cont_pre_first", s10, 5'b1_11_11);
        check("cont_pre_second", s11, 5'b1_00_00);
        check("cont_sfd_first", s26, 5'b1_1110);
        check("cont_payload", s30, 5'b1_1100);
        sym_en = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
